upcounter_mod_tick: RTL and testbench
=====================================

// Module: upcounter_mod_tick
//
// PURPOSE
//  Loadable, modulo-N up-counter with a built-in tick prescaler and a cascade carry.
//  - The prescaler turns the board clock into a slow step strobe (e.g. 1 Hz from 50 MHz).
//    The counter advances once per strobe.
//  - tc and co let several instances chain into multi-digit counters (e.g. BCD seconds/minutes).
//  - The state is held in per-bit enable flops, the same structure as the team's flop-based down-counters.
//
// PARAMETERS
//  WIDTH     4           counter width in bits
//  MODULUS   16          count sequence 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
//  PRESCALE  50_000_000  enabled clk cycles per count step; PRESCALE=1 steps every enabled cycle
//
// PORTS
//  clk   in   1      single clock, rising edge
//  rst   in   1      asynchronous, active-low reset
//  en    in   1      count enable; gates both the prescaler and the counter
//  load  in   1      synchronous load strobe
//  din   in   WIDTH  load value
//  q     out  WIDTH  current count
//  tick  out  1      step strobe; one cycle wide
//  tc    out  1      terminal count: q == MODULUS-1
//  co    out  1      carry-out: tc & tick; drive the next stage's en with it
//
// BEHAVIOUR
//  - Reset (rst=0): takes effect immediately, with no clock needed.
//    Sets q=0 and prescaler=0; tick=0 and co=0 while reset is held; tc=0 (valid because MODULUS>=2).
//  - Prescaler: pre counts 0..PRESCALE-1 and wraps to 0.
//    Its width is max(1, $clog2(PRESCALE)).
//    It increments only on edges where en=1 and load=0, and holds when en=0.
//  - tick = en & (pre == PRESCALE-1). Combinational, with no added latency.
//  - Counter update on each rising edge, highest priority first:
//    1. load=1: q <= din if din < MODULUS, else q <= MODULUS-1 (saturate). pre <= 0.
//       Load acts regardless of en.
//    2. tick=1: if q == MODULUS-1 then q <= 0 (wrap); else q <= q+1.
//    3. Otherwise q holds.
//  - tc = (q == MODULUS-1), combinational from q.
//  - co = tc & tick. It is high for exactly the one cycle whose edge wraps q to 0.
//  - load and tick in the same cycle: load wins. The step is lost and the prescaler restarts from 0.
//    tick and co still read high combinationally in that cycle; downstream stages must qualify them with load when this matters.
//  - en=0: q and pre hold; tick=0; co=0; tc still follows q.
//  - Reset asserted mid-operation: immediate clear as above.
//    The first step after release occurs PRESCALE enabled cycles later.
//  - No X on any output after reset; all arithmetic is unsigned.
//    Adders are WIDTH bits wide; the wrap is explicit, never implied by overflow (unless MODULUS == 2**WIDTH).
//
// STRUCTURE
//  - Shared package holds:
//    - the parameter legality check macro/function (MODULUS, PRESCALE ranges);
//    - the common constant for the board 1 Hz prescale (50_000_000).
//  - One sub-module: dff_en_arn, a D flop with enable and an asynchronous active-low clear.
//  - The top level instantiates WIDTH copies of dff_en_arn for q via a generate loop.
//    Next-state is computed combinationally from load, tick and tc.
//    The prescaler is a plain always block in the top level.
//  - Elaboration-time check fails the build if MODULUS or PRESCALE is out of range.
//
// TESTING
//  1. WIDTH=4, MODULUS=10, PRESCALE=1, en=1 for 12 cycles after reset
//     -> q = 0,1,...,9,0,1; tc and co high only while q=9.
//  2. PRESCALE=4, en=1 -> tick every 4th cycle; q steps 0->1->2 at cycles 4 and 8.
//     Drop en for 3 cycles mid-period -> q and pre freeze, tick=0.
//     Resume -> the period completes with no phase loss.
//  3. MODULUS=10: load=1, din=7 -> q=7 next edge, pre=0.
//     load=1, din=12 -> q=9 and tc=1.
//  4. load=1 in a cycle where tick=1 and q=9 -> q=din (3).
//     No wrap to 0; the next tick arrives PRESCALE cycles later.
//  5. Drop rst to 0 between edges with q=5 -> q=0 immediately, tick=0 and co=0 while held.
//     Release rst -> counting resumes from 0.
//  6. Two instances (MODULUS=10, units.co -> tens.en), PRESCALE=1, 100 cycles
//     -> tens:units sequence 00..99, then 00.

Source files
------------

// File: rtl/upcounter_mod_tick_pkg.sv
// Shared constants and parameter helpers for the modulo-N tick counter family.
package upcounter_mod_tick_pkg;

  // Board clock is 50 MHz, so this prescale gives a 1 Hz step.
  localparam int ONE_HZ_PRESCALE = 50_000_000;

  function automatic bit params_legal(input int width, input int modulus, input int prescale);
    longint span;
    if (width < 1 || width > 31) return 1'b0;
    span = longint'(1) << width;
    return (modulus >= 2) && (longint'(modulus) <= span) && (prescale >= 1);
  endfunction

  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/upcounter_mod_tick_dff_en_arn.sv
// D flop with clock enable and asynchronous active-low clear.
module dff_en_arn (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= 1'b0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/upcounter_mod_tick.sv
// Loadable modulo-N up-counter advanced by an internal prescaler strobe, with
// terminal-count and carry outputs for cascading digits.
module upcounter_mod_tick
  import upcounter_mod_tick_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = ONE_HZ_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             co
);

  if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
    $error("upcounter_mod_tick: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  localparam int               PW       = pre_width(PRESCALE);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] Q_LAST   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] load_val;
  logic             step;

  // A load restarts the period so the first step after it is a full PRESCALE away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pre <= '0;
    else if (load)
      pre <= '0;
    else if (en)
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
  end

  // Gated by rst so that tick and co stay low while reset is held, even with PRESCALE=1.
  assign tick = rst & en & (pre == PRE_LAST);
  assign tc   = (q == Q_LAST);
  assign co   = tc & tick;

  always_comb begin
    load_val = ({1'b0, din} < MOD_EXT) ? din : Q_LAST;
    step     = load | tick;
    if (load)
      q_next = load_val;
    else if (tc)
      q_next = '0;
    else
      q_next = q + WIDTH'(1);
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_q_bit
    dff_en_arn u_bit (
      .clk (clk),
      .rst (rst),
      .en  (step),
      .d   (q_next[gi]),
      .q   (q[gi])
    );
  end

endmodule

// File: tb/tb_upcounter_mod_tick.sv
// Directed bench for upcounter_mod_tick: free-running, prescaled, load, reset and cascade cases.
module tb_upcounter_mod_tick;

  logic clk;
  logic rst_a, rst_b;
  logic en_a, en_b, en_c;
  logic load_a, load_b;
  logic [3:0] din_a, din_b;
  logic [3:0] q_a, q_b, q_u, q_t;
  logic tick_a, tc_a, co_a;
  logic tick_b, tc_b, co_b;
  logic tick_u, tc_u, co_u;
  logic tick_t, tc_t, co_t;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: PRESCALE=1 decade counter
  upcounter_mod_tick #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .load(load_a), .din(din_a),
    .q(q_a), .tick(tick_a), .tc(tc_a), .co(co_a)
  );

  // B: PRESCALE=4 decade counter
  upcounter_mod_tick #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .load(load_b), .din(din_b),
    .q(q_b), .tick(tick_b), .tc(tc_b), .co(co_b)
  );

  // C: two-digit cascade, units carry drives tens enable
  upcounter_mod_tick #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_units (
    .clk(clk), .rst(rst_a), .en(en_c), .load(1'b0), .din(4'd0),
    .q(q_u), .tick(tick_u), .tc(tc_u), .co(co_u)
  );

  upcounter_mod_tick #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_tens (
    .clk(clk), .rst(rst_a), .en(co_u), .load(1'b0), .din(4'd0),
    .q(q_t), .tick(tick_t), .tc(tc_t), .co(co_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    en_a = 1'b1; en_b = 1'b0; en_c = 1'b0;
    load_a = 1'b0; load_b = 1'b0;
    din_a = 4'd0; din_b = 4'd0;

    // Reset held: everything cleared, tick gated even with en=1 and PRESCALE=1
    #12;
    check("rst_q_a", 32'(q_a), 0);
    check("rst_tc_a", 32'(tc_a), 0);
    check("rst_tick_a", 32'(tick_a), 0);
    check("rst_co_a", 32'(co_a), 0);
    check("rst_q_b", 32'(q_b), 0);
    check("rst_cascade", 32'({q_t, q_u}), 0);

    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;

    // 1: PRESCALE=1 counts every cycle, wraps after 9
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t1_q[%0d]", i), 32'(q_a), 32'(i % 10));
      check($sformatf("t1_tc[%0d]", i), 32'(tc_a), 32'((i % 10) == 9));
      check($sformatf("t1_co[%0d]", i), 32'(co_a), 32'((i % 10) == 9));
      $display("t1 cycle %0d q=%0d tc=%0d co=%0d", i, q_a, tc_a, co_a);
      cyc();
    end

    // 2: PRESCALE=4 steps every 4th enabled cycle
    en_b = 1'b1;
    #1;
    check("t2_tick_start", 32'(tick_b), 0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("t2_q[%0d]", k), 32'(q_b), 32'(k / 4));
      check($sformatf("t2_tick[%0d]", k), 32'(tick_b), 32'((k % 4) == 3));
      $display("t2 cycle %0d q=%0d tick=%0d", k, q_b, tick_b);
    end
    cyc();
    cyc();
    en_b = 1'b0;
    #1;
    check("t2_frz_tick0", 32'(tick_b), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("t2_frz_q[%0d]", k), 32'(q_b), 2);
      check($sformatf("t2_frz_tick[%0d]", k), 32'(tick_b), 0);
    end
    en_b = 1'b1;
    #1;
    check("t2_res_tick_a", 32'(tick_b), 0);
    cyc();
    check("t2_res_tick_b", 32'(tick_b), 1);
    check("t2_res_q_a", 32'(q_b), 2);
    cyc();
    check("t2_res_q_b", 32'(q_b), 3);
    check("t2_res_tick_c", 32'(tick_b), 0);
    $display("t2 resume q=%0d", q_b);

    // 3: load in range, then saturating load
    load_b = 1'b1; din_b = 4'd7;
    cyc();
    check("t3_load7", 32'(q_b), 7);
    din_b = 4'd12;
    cyc();
    check("t3_load12", 32'(q_b), 9);
    check("t3_tc", 32'(tc_b), 1);
    load_b = 1'b0;
    $display("t3 load q=%0d tc=%0d", q_b, tc_b);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("t3_tick[%0d]", k), 32'(tick_b), 32'(k == 3));
    end
    check("t3_co", 32'(co_b), 1);

    // 4: load beats tick at terminal count
    load_b = 1'b1; din_b = 4'd3;
    #1;
    check("t4_tick_w_load", 32'(tick_b), 1);
    check("t4_co_w_load", 32'(co_b), 1);
    cyc();
    load_b = 1'b0;
    #1;
    check("t4_q", 32'(q_b), 3);
    check("t4_tick_after", 32'(tick_b), 0);
    $display("t4 load-over-tick q=%0d", q_b);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("t4_tick[%0d]", k), 32'(tick_b), 32'(k == 3));
    end
    cyc();
    check("t4_q_step", 32'(q_b), 4);

    // 5: asynchronous reset mid-period
    repeat (4) cyc();
    check("t5_q5", 32'(q_b), 5);
    cyc();
    cyc();
    rst_b = 1'b0;
    #1;
    check("t5_q_clr", 32'(q_b), 0);
    check("t5_tick_clr", 32'(tick_b), 0);
    check("t5_co_clr", 32'(co_b), 0);
    check("t5_tc_clr", 32'(tc_b), 0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      check($sformatf("t5_hold_q[%0d]", k), 32'(q_b), 0);
      check($sformatf("t5_hold_tick[%0d]", k), 32'(tick_b), 0);
    end
    rst_b = 1'b1;
    #1;
    check("t5_rel_q", 32'(q_b), 0);
    check("t5_rel_tick", 32'(tick_b), 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("t5_tick[%0d]", k), 32'(tick_b), 32'(k == 3));
    end
    cyc();
    check("t5_q_first", 32'(q_b), 1);
    $display("t5 reset release q=%0d", q_b);

    // 6: two-digit cascade 00..99 then 00
    en_c = 1'b1;
    #1;
    for (int i = 0; i <= 100; i++) begin
      check($sformatf("t6_val[%0d]", i), 32'(int'(q_t) * 10 + int'(q_u)), 32'(i % 100));
      check($sformatf("t6_co[%0d]", i), 32'(co_u), 32'((i % 10) == 9));
      $display("t6 cycle %0d tens=%0d units=%0d", i, q_t, q_u);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
